// File: rtl/spi_pix_injector.sv
// spi_pix_injector: SPI command decoder, register file and pixel injector.
// Commands: 0x80 a d (write), 0x81 a (read), 0x55 (stream), 0x40/0x41 (screen
// reset clear/set), 0x42 (clear coordinates and error).
// Optional build macro SPI_INJ_STATUS_EN adds a read-only status byte at
// address REG_N: {err, stream, scr_rst, 5-bit frame count}.
//
// state  | meaning
// IDLE   | waiting for the command byte of a transaction
// ARG1   | waiting for the address byte of a read or write
// ARG2   | waiting for the data byte of a write
// STREAM | packing bytes into pixels
// DONE   | command finished, remaining bytes ignored until cs drops
module spi_pix_injector #(
  parameter int CH    = 2,
  parameter int BPP   = 3,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int REG_N = 8
) (
  input  logic                    clk_p,
  input  logic                    rst_p,
  input  logic                    cs_act,
  input  logic                    byte_vld,
  input  logic [7:0]              byte_dat,
  input  logic [7:0]              ret_dat,
  output logic [7:0]              feed_dat,
  output logic [8*REG_N-1:0]      reg_q,
  output logic                    scr_rst,
  output logic                    stream,
  output logic                    pix_vld,
  output logic [8*CH*BPP-1:0]     pix_dat,
  output logic [10:0]             pix_x,
  output logic [10:0]             pix_y,
  output logic                    sol,
  output logic                    eof,
  output logic                    err
);

  localparam int NB = CH * BPP;
  localparam int PW = 8 * NB;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [10:0]   X_LAST   = 11'(IMG_W - 1);
  localparam logic [10:0]   Y_LAST   = 11'(IMG_H - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_ARG1, ST_ARG2, ST_STREAM, ST_DONE} state_t;

  state_t          state, state_nxt;
  logic            cs_q, cs_fall, byte_ok;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   grp, grp_nxt, grp_shift, pdat_nxt;
  logic [7:0]      addr_q, addr_nxt, feed_nxt, rd_val;
  logic            rd_cmd, rd_nxt, wr_en;
  logic            scr_nxt, err_nxt, vld_nxt, sol_nxt, eof_nxt;
  logic [10:0]     x_adv, y_adv, x_nxt, y_nxt;
`ifdef SPI_INJ_STATUS_EN
  logic [4:0]      frm_cnt;
`endif

  // A dropping chip select wins over a byte arriving in the same cycle.
  assign cs_fall   = cs_q & ~cs_act;
  assign byte_ok   = byte_vld & cs_act;
  assign grp_shift = (grp << 8) | PW'(byte_dat);

  // Parser state register.
  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Parser next state: byte index restarts on every cs falling edge.
  always_comb begin
    state_nxt = state;
    if (cs_fall) begin
      state_nxt = ST_IDLE;
    end else if (byte_ok) begin
      case (state)
        ST_IDLE: begin
          case (byte_dat)
            8'h80, 8'h81: state_nxt = ST_ARG1;
            8'h55:        state_nxt = ST_STREAM;
            default:      state_nxt = ST_IDLE;
          endcase
        end
        ST_ARG1:   state_nxt = rd_cmd ? ST_DONE : ST_ARG2;
        ST_ARG2:   state_nxt = ST_DONE;
        ST_STREAM: state_nxt = ST_STREAM;
        default:   state_nxt = ST_DONE;
      endcase
    end
  end

  // Readback mux for the read command address byte.
  always_comb begin
    rd_val = 8'hFF;
    for (int i = 0; i < REG_N; i++)
      if (byte_dat == 8'(i)) rd_val = reg_q[8*i +: 8];
`ifdef SPI_INJ_STATUS_EN
    if (byte_dat == 8'(REG_N)) rd_val = {err, stream, scr_rst, frm_cnt};
`endif
  end

  // Output/datapath next values for the current byte and cs edge.
  always_comb begin
    feed_nxt = feed_dat;
    scr_nxt  = scr_rst;
    err_nxt  = err;
    cnt_nxt  = cnt;
    grp_nxt  = grp;
    addr_nxt = addr_q;
    rd_nxt   = rd_cmd;
    pdat_nxt = pix_dat;
    vld_nxt  = 1'b0;
    sol_nxt  = 1'b0;
    eof_nxt  = 1'b0;
    wr_en    = 1'b0;
    // Coordinates step one cycle after each emitted pixel.
    x_adv = pix_x;
    y_adv = pix_y;
    if (pix_vld) begin
      if (pix_x == X_LAST) begin
        x_adv = '0;
        y_adv = (pix_y == Y_LAST) ? 11'd0 : pix_y + 11'd1;
      end else begin
        x_adv = pix_x + 11'd1;
      end
    end
    x_nxt = x_adv;
    y_nxt = y_adv;
    if (cs_fall) begin
      if (cnt != '0) err_nxt = 1'b1;
      cnt_nxt = '0;
      grp_nxt = '0;
    end else if (byte_ok) begin
      feed_nxt = 8'hFF;
      case (state)
        ST_IDLE: begin
          case (byte_dat)
            8'h80: rd_nxt = 1'b0;
            8'h81: rd_nxt = 1'b1;
            8'h40: scr_nxt = 1'b0;
            8'h41: scr_nxt = 1'b1;
            8'h42: begin
              x_nxt   = '0;
              y_nxt   = '0;
              err_nxt = 1'b0;
            end
            default: ;
          endcase
        end
        ST_ARG1: begin
          addr_nxt = byte_dat;
          if (rd_cmd) feed_nxt = rd_val;
        end
        ST_ARG2: wr_en = 1'b1;
        ST_STREAM: begin
          feed_nxt = ret_dat;
          if (cnt == CNT_LAST) begin
            vld_nxt  = 1'b1;
            pdat_nxt = grp_shift;
            sol_nxt  = (x_adv == 11'd0);
            eof_nxt  = (x_adv == X_LAST) && (y_adv == Y_LAST);
            cnt_nxt  = '0;
            grp_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
            grp_nxt = grp_shift;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs, register file and pixel assembly.
  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p) begin
      cs_q     <= 1'b0;
      feed_dat <= 8'hFF;
      reg_q    <= '0;
      scr_rst  <= 1'b0;
      stream   <= 1'b0;
      pix_vld  <= 1'b0;
      pix_dat  <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
      sol      <= 1'b0;
      eof      <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      grp      <= '0;
      addr_q   <= '0;
      rd_cmd   <= 1'b0;
    end else begin
      cs_q     <= cs_act;
      feed_dat <= feed_nxt;
      scr_rst  <= scr_nxt;
      stream   <= (state_nxt == ST_STREAM);
      pix_vld  <= vld_nxt;
      pix_dat  <= pdat_nxt;
      pix_x    <= x_nxt;
      pix_y    <= y_nxt;
      sol      <= sol_nxt;
      eof      <= eof_nxt;
      err      <= err_nxt;
      cnt      <= cnt_nxt;
      grp      <= grp_nxt;
      addr_q   <= addr_nxt;
      rd_cmd   <= rd_nxt;
      if (wr_en)
        for (int i = 0; i < REG_N; i++)
          if (addr_q == 8'(i)) reg_q[8*i +: 8] <= byte_dat;
    end
  end

`ifdef SPI_INJ_STATUS_EN
  // Frame counter: one count per emitted last-pixel-of-frame, wraps at 31.
  always_ff @(posedge clk_p or negedge rst_p) begin
    if (!rst_p)             frm_cnt <= '0;
    else if (pix_vld & eof) frm_cnt <= frm_cnt + 5'd1;
  end
`endif

endmodule
